// File: rtl/clk_enable_bank_pkg.sv
// Shared types and helpers for the clk_enable_bank clock-enable generator.
package clk_enable_bank_pkg;

  typedef enum logic [1:0] {
    WAIT,
    SETTLE,
    RUN,
    RELOAD
  } state_t;

  function automatic int settle_cnt_w(input int lock_cycles);
    return (lock_cycles < 1) ? 1 : $clog2(lock_cycles + 1);
  endfunction

endpackage

// File: rtl/clk_enable_chan.sv
// One divided clock-enable channel: modulo-N counter with ce and 50%-duty decode.
module clk_enable_chan #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] phase,
  output logic             ce,
  output logic             div_out
);

  logic [DIV_W-1:0] n_q, cnt_q;
  logic [DIV_W-1:0] n_d, cnt_d, start, wrap_cnt;
  logic             ce_d, div_d;

  // Outputs are decoded from the next count so they line up with the counter.
  always_comb begin
    start = '0;
    if (div != '0)
      start = (phase > div - DIV_W'(1)) ? div - DIV_W'(1) : phase;

    wrap_cnt = '0;
    if (n_q != '0 && cnt_q != n_q - DIV_W'(1))
      wrap_cnt = cnt_q + DIV_W'(1);

    n_d   = load ? div : n_q;
    cnt_d = load ? start : (run ? wrap_cnt : cnt_q);

    ce_d  = run && (n_d != '0) && (cnt_d == n_d - DIV_W'(1));
    div_d = run && (n_d != '0) && (cnt_d < n_d - (n_d >> 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q     <= '0;
      cnt_q   <= '0;
      ce      <= 1'b0;
      div_out <= 1'b0;
    end else begin
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      ce      <= ce_d;
      div_out <= div_d;
    end
  end

endmodule

// File: rtl/clk_enable_bank.sv
// Lock-gated bank of NUM_CH programmable clock-enables with atomic, phase-aligned reconfiguration.
module clk_enable_bank
  import clk_enable_bank_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] cfg_div,
  input  logic [NUM_CH*DIV_W-1:0] cfg_phase,
  input  logic                    cfg_load,
  output logic                    cfg_ack,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       div_out,
  output logic                    locked
);

  localparam int CNT_W = settle_cnt_w(LOCK_CYCLES);

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    lk_s;
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        settle_q;
  logic                    pending_q;
  logic [NUM_CH*DIV_W-1:0] sh_div_q, sh_phase_q;
  logic                    chan_load, chan_run, ack_d;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign lk_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT:    state_d = SETTLE;
      SETTLE:  if (settle_q == CNT_W'(LOCK_CYCLES - 1)) state_d = RUN;
      RUN:     if (pending_q) state_d = RELOAD;
      RELOAD:  state_d = RUN;
      default: state_d = WAIT;
    endcase
    if (!lk_s) state_d = WAIT;
  end

  // Channels latch the shadow on every edge into RUN; a load absorbed from SETTLE still acks.
  always_comb begin
    chan_run  = (state_d == RUN);
    chan_load = chan_run && (state_q == SETTLE || state_q == RELOAD);
    ack_d     = (state_d == RELOAD) || (chan_load && state_q == SETTLE && pending_q);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q   <= '0;
      pending_q  <= 1'b0;
      sh_div_q   <= '0;
      sh_phase_q <= '0;
      locked     <= 1'b0;
      cfg_ack    <= 1'b0;
    end else begin
      settle_q <= (state_q == SETTLE && state_d == SETTLE) ? settle_q + CNT_W'(1) : '0;
      if (cfg_load) begin
        sh_div_q   <= cfg_div;
        sh_phase_q <= cfg_phase;
        pending_q  <= 1'b1;
      end else if (chan_load) begin
        pending_q  <= 1'b0;
      end
      locked  <= chan_run;
      cfg_ack <= ack_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clk_enable_chan #(.DIV_W(DIV_W)) u_chan (
      .clk     (refclk),
      .rst_n   (rst_n),
      .load    (chan_load),
      .run     (chan_run),
      .div     (sh_div_q[i*DIV_W +: DIV_W]),
      .phase   (sh_phase_q[i*DIV_W +: DIV_W]),
      .ce      (ce[i]),
      .div_out (div_out[i])
    );
  end

endmodule

// File: tb/tb_clk_enable_bank.sv
// Randomised self-checking bench for clk_enable_bank against a cycle-level behavioural model.
module tb_clk_enable_bank;

  localparam int NUM_CH      = 3;
  localparam int DIV_W       = 8;
  localparam int LOCK_CYCLES = 16;
  localparam int SYNC_STAGES = 2;

  logic                    refclk     = 1'b0;
  logic                    rst_n      = 1'b0;
  logic                    pll_locked = 1'b0;
  logic                    cfg_load   = 1'b0;
  logic [NUM_CH*DIV_W-1:0] cfg_div    = '0;
  logic [NUM_CH*DIV_W-1:0] cfg_phase  = '0;
  logic                    cfg_ack;
  logic [NUM_CH-1:0]       ce, div_out;
  logic                    locked;

  always #5 refclk = ~refclk;

  clk_enable_bank #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .LOCK_CYCLES (LOCK_CYCLES),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .cfg_div    (cfg_div),
    .cfg_phase  (cfg_phase),
    .cfg_load   (cfg_load),
    .cfg_ack    (cfg_ack),
    .ce         (ce),
    .div_out    (div_out),
    .locked     (locked)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 = outputs off, 1 = settling, 2 = running, 3 = reconfiguring.
  int m_sync [SYNC_STAGES];
  int m_mode, m_settle, m_k, m_pend, m_ack;
  int m_act_n [NUM_CH];
  int m_act_p [NUM_CH];
  int m_sh_n  [NUM_CH];
  int m_sh_p  [NUM_CH];
  int edge_no   = 0;
  int seen_lock = 0;

  task automatic model_reset();
    for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_act_n[i] = 0; m_act_p[i] = 0; m_sh_n[i] = 0; m_sh_p[i] = 0;
    end
    m_mode = 0; m_settle = 0; m_k = 0; m_pend = 0; m_ack = 0;
  endtask

  task automatic start_run();
    m_mode = 2;
    m_k    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_act_n[i] = m_sh_n[i];
      m_act_p[i] = m_sh_p[i];
    end
  endtask

  task automatic model_edge();
    int lk;
    lk    = m_sync[SYNC_STAGES-1];
    m_ack = 0;
    if (lk == 0) begin
      m_mode   = 0;
      m_settle = 0;
    end else begin
      case (m_mode)
        0: begin m_mode = 1; m_settle = 0; end
        1: begin
          m_settle++;
          if (m_settle == LOCK_CYCLES) begin
            start_run();
            m_ack  = m_pend;
            m_pend = 0;
          end
        end
        2: begin
          if (m_pend != 0) begin m_mode = 3; m_ack = 1; end
          else m_k++;
        end
        default: begin start_run(); m_pend = 0; end
      endcase
    end
    if (cfg_load) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_sh_n[i] = int'(cfg_div[i*DIV_W +: DIV_W]);
        m_sh_p[i] = int'(cfg_phase[i*DIV_W +: DIV_W]);
      end
      m_pend = 1;
    end
    for (int i = SYNC_STAGES - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = int'(pll_locked);
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0] xc, xd;
    int n, p, c;
    xc = '0;
    xd = '0;
    if (m_mode == 2) begin
      for (int i = 0; i < NUM_CH; i++) begin
        n = m_act_n[i];
        if (n != 0) begin
          p = (m_act_p[i] > n - 1) ? n - 1 : m_act_p[i];
          c = (p + m_k) % n;
          xc[i] = (c == n - 1);
          xd[i] = (c < n - n / 2);
        end
      end
    end
    check_val("locked",  int'(locked),  int'(m_mode == 2));
    check_val("cfg_ack", int'(cfg_ack), m_ack);
    check_val("ce",      int'(ce),      int'(xc));
    check_val("div_out", int'(div_out), int'(xd));
    if (seen_lock == 0 && locked === 1'b1) begin
      seen_lock = 1;
      check_val("lock_latency", edge_no, SYNC_STAGES + LOCK_CYCLES + 1);
    end
  endtask

  task automatic cycle();
    @(posedge refclk);
    edge_no++;
    model_edge();
    @(negedge refclk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_cfg(input int n0, input int n1, input int n2,
                         input int p0, input int p1, input int p2);
    cfg_div   = {DIV_W'(n2), DIV_W'(n1), DIV_W'(n0)};
    cfg_phase = {DIV_W'(p2), DIV_W'(p1), DIV_W'(p0)};
  endtask

  task automatic set_cfg_rand();
    set_cfg($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12),
            $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
  endtask

  task automatic pulse_load();
    cfg_load = 1'b1;
    cycle();
    cfg_load = 1'b0;
  endtask

  // Called just after a negedge: reset is held for roughly half a cycle.
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    model_reset();
    pll_locked = 1'b1;
    #2 rst_n = 1'b1;
    #1 compare_all();

    run(5);
    set_cfg(4, 3, 1, 0, 0, 0);
    pulse_load();
    run(40);

    set_cfg(5, 5, 0, 2, 9, 0);
    pulse_load();
    run(30);

    set_cfg(2, 2, 2, 0, 0, 0);
    pulse_load();
    run(10);

    pll_locked = 1'b0;
    cycle();
    pll_locked = 1'b1;
    run(30);

    set_cfg(5, 0, 3, 1, 0, 2);
    pulse_load();
    run(110);

    set_cfg(3, 4, 6, 1, 2, 3);
    pulse_load();
    cycle();
    set_cfg(7, 2, 5, 6, 1, 0);
    pulse_load();
    run(20);

    set_cfg(6, 6, 6, 0, 1, 2);
    pulse_load();
    set_cfg(9, 8, 7, 3, 3, 3);
    pulse_load();
    run(25);

    async_reset();
    run(25);
    set_cfg(4, 7, 1, 3, 5, 0);
    pulse_load();
    run(30);

    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        set_cfg_rand();
        pulse_load();
      end else if (r == 4) begin
        pll_locked = 1'b0;
        run($urandom_range(1, 3));
        pll_locked = 1'b1;
      end else if (r == 5) begin
        set_cfg_rand();
        pulse_load();
        set_cfg_rand();
        pulse_load();
      end else if (r == 6) begin
        set_cfg_rand();
        pulse_load();
        cycle();
        set_cfg_rand();
        pulse_load();
      end
      run($urandom_range(1, 30));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
